// File: rtl/aes_round_ctrl_if.sv
// Host/datapath handshake and strobe bundle for the AES round sequencer.
// blk_cnt is present only when AES_CTRL_BLK_CNT_EN is defined.
interface aes_round_ctrl_if #(
   parameter int ROUND_W = 4
);
   logic               in_valid;
   logic               in_ready;
   logic               out_valid;
   logic               out_ready;
   logic               dp_load;
   logic               ks_load;
   logic               dp_round_en;
   logic               ks_step;
   logic [ROUND_W-1:0] dp_round_idx;
   logic               dp_final;
   logic               out_capture;
   logic               busy;
`ifdef AES_CTRL_BLK_CNT_EN
   logic [31:0]        blk_cnt;
`endif

   modport master (
      output in_valid, out_ready,
      input  in_ready, out_valid, dp_load, ks_load, dp_round_en, ks_step,
             dp_round_idx, dp_final, out_capture, busy
`ifdef AES_CTRL_BLK_CNT_EN
      , input blk_cnt
`endif
   );

   modport slave (
      input  in_valid, out_ready,
      output in_ready, out_valid, dp_load, ks_load, dp_round_en, ks_step,
             dp_round_idx, dp_final, out_capture, busy
`ifdef AES_CTRL_BLK_CNT_EN
      , output blk_cnt
`endif
   );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128/256 round sequencer: LOAD -> ROUND x(N-1) -> FINAL -> HOLD.
// Optional completed-block counter enabled by defining AES_CTRL_BLK_CNT_EN.
module aes_round_ctrl #(
   parameter int NUM_ROUNDS = 10,
   parameter int ROUND_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   aes_round_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, HOLD} state_t;

   localparam logic [ROUND_W-1:0] LAST_MID = ROUND_W'(NUM_ROUNDS - 1);

   state_t             state_q, state_d;
   logic [ROUND_W-1:0] rnd_q, rnd_d;

   logic               in_ready, out_valid, dp_load, ks_load, dp_round_en;
   logic               ks_step, dp_final, out_capture, busy;
   logic [ROUND_W-1:0] dp_round_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rnd_q   <= '0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      case (state_q)
         IDLE: if (bus.in_valid) begin
            state_d = LOAD;
            rnd_d   = '0;
         end
         LOAD: begin
            state_d = ROUND;
            rnd_d   = ROUND_W'(1);
         end
         ROUND: begin
            rnd_d = rnd_q + ROUND_W'(1);
            if (rnd_q == LAST_MID) state_d = FINAL;
         end
         FINAL: state_d = HOLD;
         HOLD: if (bus.out_ready) begin
            state_d = IDLE;
            rnd_d   = '0;
         end
         default: begin
            state_d = IDLE;
            rnd_d   = '0;
         end
      endcase
   end

   // Outputs come from registered state only; rst blanks them while asserted.
   always_comb begin
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      dp_load      = 1'b0;
      ks_load      = 1'b0;
      dp_round_en  = 1'b0;
      ks_step      = 1'b0;
      dp_final     = 1'b0;
      out_capture  = 1'b0;
      busy         = 1'b0;
      dp_round_idx = '0;
      if (!rst) begin
         case (state_q)
            IDLE: in_ready = 1'b1;
            LOAD: begin
               dp_load = 1'b1;
               ks_load = 1'b1;
               busy    = 1'b1;
            end
            ROUND: begin
               dp_round_en  = 1'b1;
               ks_step      = 1'b1;
               busy         = 1'b1;
               dp_round_idx = rnd_q;
            end
            FINAL: begin
               dp_round_en  = 1'b1;
               ks_step      = 1'b1;
               dp_final     = 1'b1;
               out_capture  = 1'b1;
               busy         = 1'b1;
               dp_round_idx = rnd_q;
            end
            HOLD: begin
               out_valid    = 1'b1;
               busy         = 1'b1;
               dp_round_idx = rnd_q;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = out_valid;
   assign bus.dp_load      = dp_load;
   assign bus.ks_load      = ks_load;
   assign bus.dp_round_en  = dp_round_en;
   assign bus.ks_step      = ks_step;
   assign bus.dp_round_idx = dp_round_idx;
   assign bus.dp_final     = dp_final;
   assign bus.out_capture  = out_capture;
   assign bus.busy         = busy;

`ifdef AES_CTRL_BLK_CNT_EN
   logic [31:0] blk_cnt_q;

   // Counts output handshakes, saturating; aborted blocks never reach HOLD.
   always_ff @(posedge clk) begin
      if (rst)
         blk_cnt_q <= '0;
      else if (state_q == HOLD && bus.out_ready && blk_cnt_q != 32'hFFFF_FFFF)
         blk_cnt_q <= blk_cnt_q + 32'd1;
   end

   assign bus.blk_cnt = rst ? 32'd0 : blk_cnt_q;
`endif
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Drives an AES-128 (10 round) and an AES-256 (14 round) sequencer with the same
// host stimulus and compares every output each cycle against a block-age model.
module tb_aes_round_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;

   always #5 clk = ~clk;

   aes_round_ctrl_if #(.ROUND_W(4)) bus0 ();
   aes_round_ctrl_if #(.ROUND_W(4)) bus1 ();

   assign bus0.in_valid  = in_valid;
   assign bus0.out_ready = out_ready;
   assign bus1.in_valid  = in_valid;
   assign bus1.out_ready = out_ready;

   aes_round_ctrl #(.NUM_ROUNDS(10), .ROUND_W(4)) u_aes128 (
      .clk(clk), .rst(rst), .bus(bus0));
   aes_round_ctrl #(.NUM_ROUNDS(14), .ROUND_W(4)) u_aes256 (
      .clk(clk), .rst(rst), .bus(bus1));

   typedef struct packed {
      logic        in_ready;
      logic        out_valid;
      logic        dp_load;
      logic        ks_load;
      logic        dp_round_en;
      logic        ks_step;
      logic        dp_final;
      logic        out_capture;
      logic        busy;
      logic [3:0]  idx;
      logic [31:0] blk;
   } outs_t;

   outs_t obs [2];

`ifdef AES_CTRL_BLK_CNT_EN
   assign obs[0] = {bus0.in_ready, bus0.out_valid, bus0.dp_load, bus0.ks_load,
                    bus0.dp_round_en, bus0.ks_step, bus0.dp_final, bus0.out_capture,
                    bus0.busy, bus0.dp_round_idx, bus0.blk_cnt};
   assign obs[1] = {bus1.in_ready, bus1.out_valid, bus1.dp_load, bus1.ks_load,
                    bus1.dp_round_en, bus1.ks_step, bus1.dp_final, bus1.out_capture,
                    bus1.busy, bus1.dp_round_idx, bus1.blk_cnt};
`else
   assign obs[0] = {bus0.in_ready, bus0.out_valid, bus0.dp_load, bus0.ks_load,
                    bus0.dp_round_en, bus0.ks_step, bus0.dp_final, bus0.out_capture,
                    bus0.busy, bus0.dp_round_idx, 32'd0};
   assign obs[1] = {bus1.in_ready, bus1.out_valid, bus1.dp_load, bus1.ks_load,
                    bus1.dp_round_en, bus1.ks_step, bus1.dp_final, bus1.out_capture,
                    bus1.busy, bus1.dp_round_idx, 32'd0};
`endif

   // Model: a block is "age" cycles old after acceptance; 1 = load,
   // 2..NR+1 = rounds (last is final), NR+2.. = waiting for the host.
   int          nr     [2] = '{10, 14};
   bit          active [2];
   int          age    [2];
   logic [31:0] done   [2];
   int          ks_cnt [2];

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input int k, input logic [31:0] o, input logic [31:0] e);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, o, e);
      end
   endtask

   function automatic outs_t expect_outs(input int k, input bit r);
      outs_t e;
      e = '0;
      if (!r) begin
         e.blk = done[k];
         if (!active[k]) e.in_ready = 1'b1;
         else if (age[k] == 1) begin
            e.dp_load = 1'b1;
            e.ks_load = 1'b1;
            e.busy    = 1'b1;
         end else if (age[k] <= nr[k] + 1) begin
            e.dp_round_en = 1'b1;
            e.ks_step     = 1'b1;
            e.busy        = 1'b1;
            e.idx         = 4'(age[k] - 1);
            e.dp_final    = (age[k] == nr[k] + 1);
            e.out_capture = (age[k] == nr[k] + 1);
         end else begin
            e.out_valid = 1'b1;
            e.busy      = 1'b1;
            e.idx       = 4'(nr[k]);
         end
      end
      return e;
   endfunction

   task automatic step(input bit r, input bit iv, input bit ordy);
      outs_t e;
      @(negedge clk);
      rst = r;
      in_valid = iv;
      out_ready = ordy;
      #1;
      for (int k = 0; k < 2; k++) begin
         e = expect_outs(k, r);
         chk("in_ready",    k, 32'(obs[k].in_ready),    32'(e.in_ready));
         chk("out_valid",   k, 32'(obs[k].out_valid),   32'(e.out_valid));
         chk("dp_load",     k, 32'(obs[k].dp_load),     32'(e.dp_load));
         chk("ks_load",     k, 32'(obs[k].ks_load),     32'(e.ks_load));
         chk("dp_round_en", k, 32'(obs[k].dp_round_en), 32'(e.dp_round_en));
         chk("ks_step",     k, 32'(obs[k].ks_step),     32'(e.ks_step));
         chk("dp_final",    k, 32'(obs[k].dp_final),    32'(e.dp_final));
         chk("out_capture", k, 32'(obs[k].out_capture), 32'(e.out_capture));
         chk("busy",        k, 32'(obs[k].busy),        32'(e.busy));
         chk("round_idx",   k, 32'(obs[k].idx),         32'(e.idx));
`ifdef AES_CTRL_BLK_CNT_EN
         chk("blk_cnt",     k, obs[k].blk,              e.blk);
`endif
         if (obs[k].ks_step === 1'b1) ks_cnt[k]++;
         // Advance the model across the coming rising edge.
         if (r) begin
            active[k] = 1'b0;
            age[k]    = 0;
            done[k]   = 32'd0;
            ks_cnt[k] = 0;
         end else if (!active[k]) begin
            if (iv) begin
               active[k] = 1'b1;
               age[k]    = 1;
               ks_cnt[k] = 0;
            end
         end else if (age[k] >= nr[k] + 2) begin
            if (ordy) begin
               chk("ks_steps_per_block", k, 32'(ks_cnt[k]), 32'(nr[k]));
               active[k] = 1'b0;
               if (done[k] != 32'hFFFF_FFFF) done[k] = done[k] + 32'd1;
            end
         end else begin
            age[k]++;
         end
      end
   endtask

   initial begin
      // Reset held for two cycles, then idle.
      step(1'b1, 1'($urandom), 1'($urandom));
      step(1'b1, 1'($urandom), 1'($urandom));
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // Single block with the host always ready.
      step(1'b0, 1'b1, 1'b1);
      repeat (20) step(1'b0, 1'b0, 1'b1);

      // Output backpressure: out_ready low long enough for both to sit in HOLD.
      step(1'b0, 1'b1, 1'b0);
      repeat (22) step(1'b0, 1'b0, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b1);

      // Request held continuously: back-to-back blocks, ignored while busy.
      repeat (45) step(1'b0, 1'b1, 1'b1);
      repeat (20) step(1'b0, 1'b0, 1'b1);

      // Reset mid-operation, then a fresh block completes.
      step(1'b0, 1'b1, 1'b1);
      repeat (6) step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      repeat (20) step(1'b0, 1'b0, 1'b1);

      // Randomised host behaviour with occasional resets.
      repeat (600) step(1'($urandom_range(0, 60) == 0), 1'($urandom), 1'($urandom));

      repeat (20) step(1'b0, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
